// File: rtl/la_rrarb.sv
// la_rrarb: N-way round-robin arbiter with a registered one-hot grant.
// The winner keeps the grant while it requests; priority then rotates to the
// index after the last winner. Optional forced release after MAXHOLD cycles
// is compiled in with the macro LA_RRARB_TIMEOUT_EN (default: not defined).
//
// Handshake: req is level-sensitive and has no ready. A requester owns the
// resource in every cycle where its gnt bit is 1. It releases the grant by
// dropping req. gnt, gnt_vld, gnt_id and timeout all change only on a rising clk edge.
module la_rrarb #(
  parameter int N       = 4,
  parameter int MAXHOLD = 16,
  parameter     PROP    = "DEFAULT"
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic                 gnt_vld,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 timeout,
  output logic                 dbg_state
);

  localparam int             IW   = $clog2(N);
  localparam logic [IW:0]    N_L  = (IW+1)'(N);
  localparam logic [IW-1:0]  N_M1 = IW'(N - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic           vld_q, vld_d;
  logic [IW-1:0]  id_q, id_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic           to_d;
  logic           do_grant;
  logic [IW-1:0]  win;
  logic [IW:0]    pick_all;

  // PROP is a pass-through tag; MAXHOLD only matters with the timeout build.
  logic unused_cfg;
  assign unused_cfg = (PROP == "DEFAULT") ^ (MAXHOLD > 1);

  // Returns {found, index} of the first set request searching from start
  // upward with wrap. The doubled vector turns the wrap into a plain shift.
  function automatic logic [IW:0] pick(input logic [N-1:0] r,
                                       input logic [IW-1:0] start);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW-1:0]  off;
    logic [IW:0]    sum;
    dbl = {r, r} >> start;
    rot = dbl[N-1:0];
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
    sum = {1'b0, start} + {1'b0, off};
    if (sum >= N_L) sum = sum - N_L;
    return {|r, sum[IW-1:0]};
  endfunction

  assign pick_all = pick(req, ptr_q);

`ifdef LA_RRARB_TIMEOUT_EN
  localparam int            HW        = $clog2(MAXHOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAXHOLD - 1);
  logic [HW-1:0] hold_q, hold_d;
  logic          to_q;
  logic [IW:0]   pick_ex;
  // Competitors other than the current owner, used for forced release.
  assign pick_ex = pick(req & ~gnt_q, ptr_q);
`endif

  // Next-state and next-grant selection.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    id_d     = id_q;
    ptr_d    = ptr_q;
    to_d     = 1'b0;
    do_grant = 1'b0;
    win      = '0;
`ifdef LA_RRARB_TIMEOUT_EN
    hold_d   = hold_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_all[IW]) begin
          do_grant = 1'b1;
          win      = pick_all[IW-1:0];
        end
      end
      GRANT: begin
        if (req[id_q]) begin
`ifdef LA_RRARB_TIMEOUT_EN
          if (hold_q == HOLD_LAST) begin
            if (pick_ex[IW]) begin
              do_grant = 1'b1;
              win      = pick_ex[IW-1:0];
              to_d     = 1'b1;
            end else begin
              hold_d = '0;
            end
          end else begin
            hold_d = hold_q + 1'b1;
          end
`endif
        end else if (pick_all[IW]) begin
          // ptr already points at g+1, so this searches from g+1.
          do_grant = 1'b1;
          win      = pick_all[IW-1:0];
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
          id_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (do_grant) begin
      state_d = GRANT;
      gnt_d   = N'(1) << win;
      id_d    = win;
      ptr_d   = (win == N_M1) ? '0 : win + 1'b1;
`ifdef LA_RRARB_TIMEOUT_EN
      hold_d  = '0;
`endif
    end
    vld_d = (state_d == GRANT);
  end

  // Registered state, grant and rotating priority pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef LA_RRARB_TIMEOUT_EN
  // Hold counter and one-cycle forced-release pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      to_q   <= 1'b0;
    end else begin
      hold_q <= hold_d;
      to_q   <= to_d;
    end
  end
  assign timeout = to_q;
`else
  logic unused_to;
  assign unused_to = to_d;
  assign timeout   = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign gnt_vld   = vld_q;
  assign gnt_id    = id_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_la_rrarb.sv
// Bench for la_rrarb: directed vector table, a timeout sequence and
// randomized traffic against a behavioural round-robin model.
module tb_la_rrarb;

  localparam int N       = 4;
  localparam int MAXHOLD = 4;
  localparam int W       = 9;  // {state, gnt[3:0], vld, id[1:0], timeout}
`ifdef LA_RRARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic         gnt_vld;
  logic [1:0]   gnt_id;
  logic         timeout;
  logic         dbg_state;

  int checks;
  int errors;
  logic [W-1:0] exp_q[$];

  typedef struct {
    bit         rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] id;
  } vec_t;

  vec_t vecs[$];

  // Model state: owner index (-1 when idle), priority pointer, hold count.
  int m_g;
  int m_ptr;
  int m_hold;
  bit m_to;

  la_rrarb #(.N(N), .MAXHOLD(MAXHOLD), .PROP("DEFAULT")) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_vld   (gnt_vld),
    .gnt_id    (gnt_id),
    .timeout   (timeout),
    .dbg_state (dbg_state)
  );

  // Clock and reset defaults.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W-1:0] pack_exp(input logic [3:0] g, input logic [1:0] id,
                                            input bit to);
    return {(g != 4'b0), g, (g != 4'b0), id, to};
  endfunction

  // Drive one cycle of inputs; outputs are sampled 1 time unit after the edge.
  task automatic step(input bit r, input logic [3:0] q);
    rst = r;
    req = q;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name);
    logic [W-1:0] e;
    logic [W-1:0] a;
    checks++;
    a = {dbg_state, gnt, gnt_vld, gnt_id, timeout};
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s no expectation queued act=%b", name, a);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        errors++;
        $display("FAIL %s act{st,gnt,vld,id,to}=%b exp=%b", name, a, e);
      end
    end
  endtask

  // Round-robin reference: walk candidates in priority order with modulo math.
  task automatic model_step(input bit r, input logic [3:0] q);
    int start;
    int found;
    bool_blk: begin
      m_to = 1'b0;
      if (r) begin
        m_g = -1; m_ptr = 0; m_hold = 0;
        disable bool_blk;
      end
      if (m_g >= 0 && q[m_g] && !(TO_EN && m_hold == MAXHOLD - 1)) begin
        m_hold++;
        disable bool_blk;
      end
      start = (m_g < 0) ? m_ptr : (m_g + 1) % N;
      found = -1;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (start + k) % N;
        if (found < 0 && c != m_g && q[c]) found = c;
      end
      if (found >= 0) begin
        m_to   = (m_g >= 0) && q[m_g];
        m_g    = found;
        m_ptr  = (found + 1) % N;
        m_hold = 0;
      end else if (m_g >= 0 && q[m_g]) begin
        m_hold = 0;
      end else begin
        m_g = -1;
      end
    end
  endtask

  function automatic logic [W-1:0] model_exp();
    logic [3:0] g;
    logic [1:0] id;
    g  = (m_g >= 0) ? 4'(1 << m_g) : 4'b0;
    id = (m_g >= 0) ? 2'(m_g) : 2'b0;
    return pack_exp(g, id, m_to);
  endfunction

  initial begin
    logic [3:0] rq;
    logic [3:0] eg;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    req = '0;
    m_g = -1; m_ptr = 0; m_hold = 0; m_to = 1'b0;

    // Directed table: reset, first grant, no-bubble handoff, rotation,
    // sole requester hold, mid-grant reset.
    vecs = '{
      '{1, 4'b1111, 4'b0000, 2'd0}, '{1, 4'b1111, 4'b0000, 2'd0},
      '{0, 4'b1111, 4'b0001, 2'd0}, '{1, 4'b0000, 4'b0000, 2'd0},
      '{0, 4'b1010, 4'b0010, 2'd1}, '{0, 4'b1000, 4'b1000, 2'd3},
      '{0, 4'b0000, 4'b0000, 2'd0},
      '{0, 4'b1111, 4'b0001, 2'd0}, '{0, 4'b1110, 4'b0010, 2'd1},
      '{0, 4'b1101, 4'b0100, 2'd2}, '{0, 4'b1011, 4'b1000, 2'd3},
      '{0, 4'b0111, 4'b0001, 2'd0}, '{0, 4'b0000, 4'b0000, 2'd0},
      '{0, 4'b0100, 4'b0100, 2'd2}, '{0, 4'b0100, 4'b0100, 2'd2},
      '{0, 4'b0100, 4'b0100, 2'd2}, '{0, 4'b0100, 4'b0100, 2'd2},
      '{0, 4'b0100, 4'b0100, 2'd2}, '{0, 4'b0000, 4'b0000, 2'd0},
      '{0, 4'b0100, 4'b0100, 2'd2}, '{1, 4'b0100, 4'b0000, 2'd0},
      '{0, 4'b0101, 4'b0001, 2'd0}, '{0, 4'b0000, 4'b0000, 2'd0}
    };
    foreach (vecs[i]) begin
      exp_q.push_back(pack_exp(vecs[i].gnt, vecs[i].id, 1'b0));
      step(vecs[i].rst, vecs[i].req);
      check_out($sformatf("vec%0d", i));
    end

    // Constant two-way contention: forced release every MAXHOLD cycles
    // when the timeout build is active, otherwise requester 0 keeps it.
    step(1'b1, 4'b0000);
    for (int c = 0; c < 12; c++) begin
      if (TO_EN) eg = ((c / MAXHOLD) % 2 == 1) ? 4'b0010 : 4'b0001;
      else       eg = 4'b0001;
      exp_q.push_back(pack_exp(eg, (eg == 4'b0010) ? 2'd1 : 2'd0,
                               TO_EN && (c % MAXHOLD == 0) && (c > 0)));
      step(1'b0, 4'b0011);
      check_out($sformatf("hold%0d", c));
    end

    // Randomized traffic with sticky requests so grants get held.
    step(1'b1, 4'b0000);
    model_step(1'b1, 4'b0000);
    rq = '0;
    for (int c = 0; c < 400; c++) begin
      bit r;
      if ($urandom_range(0, 9) < 4) rq = 4'($urandom_range(0, 15));
      r = ($urandom_range(0, 39) == 0);
      model_step(r, rq);
      exp_q.push_back(model_exp());
      step(r, rq);
      check_out($sformatf("rand%0d", c));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
